// File: rtl/baud_tick_ctrl.sv
// Baud bit-time generator: debounced baud-select commit plus IDLE/LOAD/RUN frame timer.
// Optional mid-bit HALF strobe is built only when BAUD_TICK_HALF_EN is defined.
module baud_tick_ctrl #(
  parameter int NBITS  = 11,
  parameter int STABLE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  BAUD_SW,
  input  logic [19:0] K,
  input  logic        START,
  output logic [3:0]  BAUD_SEL,
  output logic        BTU,
  output logic        HALF,
  output logic [3:0]  BIT_CNT,
  output logic        BUSY,
  output logic        DONE,
  output logic        CHG
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [7:0]  STABLE_C = 8'(STABLE);
  localparam logic [3:0]  LAST_BIT = 4'(NBITS - 1);
  localparam logic [19:0] K_RESET  = 20'd333333;
  localparam logic [19:0] K_MIN    = 20'd2;

  state_t      state_reg, state_next;
  logic [3:0]  sw_q;
  logic [7:0]  stab_reg;
  logic [3:0]  baud_sel_reg;
  logic [19:0] k_q;
  logic [19:0] cnt_reg;
  logic [3:0]  bit_cnt_reg;
  logic        btu_reg;
  logic        done_reg;
  logic        chg_reg;

  logic [3:0]  sw_bit_diff;
  logic        sw_changing;
  logic        stab_full;
  logic        commit;
  logic        bit_end;
  logic        frame_end;
  logic [19:0] k_clamped;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sw_diff
      assign sw_bit_diff[gi] = BAUD_SW[gi] ^ sw_q[gi];
    end
  endgenerate

  assign sw_changing = |sw_bit_diff;
  assign stab_full   = (stab_reg == STABLE_C);
  assign commit      = (state_reg == IDLE) && (sw_q != baud_sel_reg) && stab_full;
  assign bit_end     = (state_reg == RUN) && (cnt_reg == k_q - 20'd1);
  assign frame_end   = bit_end && (bit_cnt_reg == LAST_BIT);
  assign k_clamped   = (K < K_MIN) ? K_MIN : K;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (START) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (frame_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Switch qualification: only counts while idle, so a frame never sees a rate change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_q         <= 4'b0000;
      stab_reg     <= 8'd0;
      baud_sel_reg <= 4'b0000;
      chg_reg      <= 1'b0;
    end else begin
      sw_q    <= BAUD_SW;
      chg_reg <= 1'b0;
      if (state_reg != IDLE) begin
        stab_reg <= 8'd0;
      end else if (commit) begin
        stab_reg     <= 8'd0;
        baud_sel_reg <= sw_q;
        chg_reg      <= 1'b1;
      end else if (sw_changing) begin
        stab_reg <= 8'd0;
      end else if (!stab_full) begin
        stab_reg <= stab_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q         <= K_RESET;
      cnt_reg     <= 20'd0;
      bit_cnt_reg <= 4'd0;
      btu_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      btu_reg  <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        LOAD: begin
          k_q         <= k_clamped;
          cnt_reg     <= 20'd0;
          bit_cnt_reg <= 4'd0;
        end
        RUN: begin
          if (bit_end) begin
            cnt_reg <= 20'd0;
            btu_reg <= 1'b1;
            if (frame_end) begin
              bit_cnt_reg <= 4'd0;
              done_reg    <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + 20'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BAUD_TICK_HALF_EN
  logic half_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_reg <= 1'b0;
    end else begin
      half_reg <= (state_reg == RUN) && (cnt_reg == (k_q >> 1));
    end
  end

  assign HALF = half_reg;
`else
  assign HALF = 1'b0;
`endif

  assign BAUD_SEL = baud_sel_reg;
  assign BTU      = btu_reg;
  assign BIT_CNT  = bit_cnt_reg;
  assign BUSY     = (state_reg != IDLE);
  assign DONE     = done_reg;
  assign CHG      = chg_reg;

endmodule

// File: tb/tb_baud_tick_ctrl.sv
// Scoreboard bench for baud_tick_ctrl: stimulus pushes expected events, a negedge monitor pops them.
module tb_baud_tick_ctrl;

  localparam int NB = 11;

  logic        clk;
  logic        reset;
  logic [3:0]  BAUD_SW;
  logic [19:0] K;
  logic        START;
  logic [3:0]  BAUD_SEL;
  logic        BTU;
  logic        HALF;
  logic [3:0]  BIT_CNT;
  logic        BUSY;
  logic        DONE;
  logic        CHG;

  baud_tick_ctrl #(.NBITS(NB), .STABLE(16)) dut (
    .clk(clk), .reset(reset), .BAUD_SW(BAUD_SW), .K(K), .START(START),
    .BAUD_SEL(BAUD_SEL), .BTU(BTU), .HALF(HALF), .BIT_CNT(BIT_CNT),
    .BUSY(BUSY), .DONE(DONE), .CHG(CHG)
  );

  typedef struct {
    int         at;
    logic [3:0] val;
  } ev_t;

  ev_t btu_q[$];
  ev_t chg_q[$];
  int  done_q[$];
  int  busy_q[$];
  int  half_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic        k_force_en;
  logic [19:0] k_force_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Baud decoder model feeding K from the committed select.
  function automatic logic [19:0] dec(input logic [3:0] sel);
    case (sel)
      4'b1000: dec = 20'd868;
      4'b1011: dec = 20'd109;
      4'b0101: dec = 20'd40;
      default: dec = 20'd20;
    endcase
  endfunction

  always_comb K = k_force_en ? k_force_val : dec(BAUD_SEL);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=1 expected=0 cyc=%0d", name, cyc);
  endtask

  // Monitor
  int         busy_len = 0;
  logic [3:0] prev_bit_cnt = 4'd0;
  ev_t        mev;
  int         mval;

  always @(negedge clk) begin
    if (reset) begin
      busy_len     = 0;
      prev_bit_cnt = 4'd0;
    end else begin
      if (BTU) begin
        if (btu_q.size() == 0) unexpected("btu_unexpected");
        else begin
          mev = btu_q.pop_front();
          chk("btu_at", cyc, mev.at);
          chk("btu_bit_cnt", int'(BIT_CNT), int'(mev.val));
          $display("btu at=%0d bit_cnt=%0d", cyc, BIT_CNT);
        end
      end
      if (DONE) begin
        if (done_q.size() == 0) unexpected("done_unexpected");
        else begin
          mval = done_q.pop_front();
          chk("done_at", cyc, mval);
          chk("done_last_bit", int'(prev_bit_cnt), NB - 1);
          chk("done_with_btu", int'(BTU), 1);
        end
      end
      if (CHG) begin
        if (chg_q.size() == 0) unexpected("chg_unexpected");
        else begin
          mev = chg_q.pop_front();
          chk("chg_at", cyc, mev.at);
          chk("chg_baud_sel", int'(BAUD_SEL), int'(mev.val));
          $display("chg at=%0d baud_sel=%b", cyc, BAUD_SEL);
        end
      end
      if (HALF) begin
`ifdef BAUD_TICK_HALF_EN
        if (half_q.size() == 0) unexpected("half_unexpected");
        else begin
          mval = half_q.pop_front();
          chk("half_at", cyc, mval);
        end
`else
        unexpected("half_when_disabled");
`endif
      end
      if (BUSY) busy_len++;
      else if (busy_len > 0) begin
        if (busy_q.size() == 0) unexpected("busy_unexpected");
        else begin
          mval = busy_q.pop_front();
          chk("busy_len", busy_len, mval);
          $display("busy len=%0d", busy_len);
        end
        busy_len = 0;
      end
      prev_bit_cnt = BIT_CNT;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse_start(output int s);
    s = cyc + 1;
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
  endtask

  // Expected events for a frame whose START is sampled at edge s, bit time k.
  task automatic push_frame(input int s, input int k, input int nbtu, input bit full);
    ev_t e;
    for (int n = 1; n <= nbtu; n++) begin
      e.at  = s + k + 1 + (n - 1) * k;
      e.val = (n == NB) ? 4'd0 : 4'(n);
      btu_q.push_back(e);
`ifdef BAUD_TICK_HALF_EN
      half_q.push_back(s + 2 + (k >> 1) + (n - 1) * k);
`endif
    end
    if (full) begin
      done_q.push_back(s + NB * k + 1);
      busy_q.push_back(NB * k + 1);
    end
  endtask

  task automatic push_chg(input int at, input logic [3:0] sel);
    ev_t e;
    e.at  = at;
    e.val = sel;
    chg_q.push_back(e);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_btu"},     int'(BTU), 0);
    chk({tag, "_half"},    int'(HALF), 0);
    chk({tag, "_done"},    int'(DONE), 0);
    chk({tag, "_chg"},     int'(CHG), 0);
    chk({tag, "_busy"},    int'(BUSY), 0);
    chk({tag, "_bit_cnt"}, int'(BIT_CNT), 0);
    chk({tag, "_sel"},     int'(BAUD_SEL), 0);
  endtask

  initial begin
    int s;
    int c;
    int d;
    int guard;

    reset       = 1'b1;
    BAUD_SW     = 4'b0000;
    START       = 1'b0;
    k_force_en  = 1'b0;
    k_force_val = 20'd0;

    // Reset state
    tick(3);
    chk_outputs_zero("reset");
    reset = 1'b0;
    tick(2);
    chk_outputs_zero("post_reset");

    // Switch 0000->1000 held: commit 17 clocks after sw_q changes, then a K=868 frame
    c = cyc;
    BAUD_SW = 4'b1000;
    push_chg(c + 18, 4'b1000);
    tick(25);
    chk("sel_1000", int'(BAUD_SEL), 4'b1000);
    pulse_start(s);
    push_frame(s, 868, NB, 1'b1);
    wait_until(s + NB * 868 + 20);

    // Commit and START in the same idle cycle; frame runs at K=109
    c = cyc;
    BAUD_SW = 4'b1011;
    push_chg(c + 18, 4'b1011);
    tick(17);
    pulse_start(s);
    chk("start_on_commit_edge", s, c + 18);
    push_frame(s, 109, NB, 1'b1);
    wait_until(s + 300);
    START = 1'b1;              // ignored while running
    tick(1);
    START = 1'b0;
    wait_until(s + 500);
    k_force_en  = 1'b1;        // K change mid-frame must not alter the period
    k_force_val = 20'd5;
    wait_until(s + 600);
    k_force_en  = 1'b0;
    wait_until(s + 1200 + 30);
    chk("busy_after_1011_frame", int'(BUSY), 0);

    // K forced to 1 clamps to 2
    k_force_en  = 1'b1;
    k_force_val = 20'd1;
    pulse_start(s);
    push_frame(s, 2, NB, 1'b1);
    wait_until(s + 2 * NB + 10);
    k_force_en  = 1'b0;

    // Switch toggling every 10 clocks never qualifies
    for (int i = 0; i < 8; i++) begin
      BAUD_SW = (i % 2 == 0) ? 4'b0101 : 4'b1011;
      tick(10);
    end
    tick(30);
    chk("sel_after_toggle", int'(BAUD_SEL), 4'b1011);

    // Switch change during RUN: commit waits for STABLE clocks of IDLE
    k_force_en  = 1'b1;
    k_force_val = 20'd30;
    pulse_start(s);
    push_frame(s, 30, NB, 1'b1);
    d = s + NB * 30 + 1;
    push_chg(d + 17, 4'b0101);
    wait_until(s + 50);
    BAUD_SW = 4'b0101;
    wait_until(s + 100);
    k_force_val = 20'd7;
    wait_until(d + 10);
    chk("sel_held_after_run", int'(BAUD_SEL), 4'b1011);
    wait_until(d + 30);
    chk("sel_0101", int'(BAUD_SEL), 4'b0101);
    k_force_en  = 1'b0;

    // Abort mid-frame at BIT_CNT=5 (K=40 from select 0101)
    pulse_start(s);
    push_frame(s, 40, 5, 1'b0);
    guard = 0;
    while (BIT_CNT != 4'd5 && guard < 500) begin
      tick(1);
      guard++;
    end
    chk("abort_reach_bit5", int'(BIT_CNT), 5);
    tick(2);
    reset   = 1'b1;
    BAUD_SW = 4'b0000;
    #1;
    chk_outputs_zero("abort");
    tick(3);
    reset = 1'b0;
    tick(600);
    chk("abort_sel", int'(BAUD_SEL), 0);
    chk("abort_busy", int'(BUSY), 0);

    chk("btu_q_left",  btu_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    chk("chg_q_left",  chg_q.size(), 0);
    chk("busy_q_left", busy_q.size(), 0);
    chk("half_q_left", half_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/baud_tick_ctrl.md
BAUD_TICK_CTRL -- requirements
Module: baud_tick_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 11, bit times per frame (start + 8 data + 2 stop); legal 2..15.
REQ-002 SHALL have parameter STABLE, default 16, clocks the switch value must hold unchanged before commit; legal 1..255.
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 BAUD_SW  in  4  raw baud-select switch setting.
REQ-006 K  in  20  bit-time count from the baud decoder; combinational function of BAUD_SEL.
REQ-007 START  in  1  request to time one frame; sampled only in IDLE.
REQ-008 BAUD_SEL  out  4  registered, committed baud select driven to the decoder.
REQ-009 BTU  out  1  one-clock pulse at the end of each bit time.
REQ-010 HALF  out  1  one-clock pulse at mid-bit.
REQ-011 BIT_CNT  out  4  index of the current bit time, 0..NBITS-1.
REQ-012 BUSY  out  1  high in LOAD and RUN.
REQ-013 DONE  out  1  one-clock pulse coincident with the final BTU of a frame.
REQ-014 CHG  out  1  one-clock pulse in the cycle after a new BAUD_SEL commits.

Function
REQ-015 FSM states SHALL be IDLE, LOAD and RUN.
REQ-016 Transitions: IDLE->LOAD on START; LOAD->RUN unconditionally; RUN->IDLE on DONE.
REQ-017 BAUD_SW SHALL be registered once (sw_q); a stability counter SHALL clear on sw_q change and increment, saturating at STABLE, while sw_q is unchanged.
REQ-018 In IDLE, with sw_q != BAUD_SEL and the stability counter == STABLE, BAUD_SEL SHALL load sw_q, CHG SHALL pulse the next cycle, and the stability counter SHALL clear.
REQ-019 In LOAD and RUN, BAUD_SEL SHALL NOT change; the stability counter SHALL be held at 0, and qualification SHALL restart in IDLE.
REQ-020 If START and a commit occur in the same IDLE cycle, both SHALL take effect, and the frame SHALL use the new rate.
REQ-021 LOAD SHALL latch K into k_q, clamped to a minimum of 2; the bit-time counter and BIT_CNT SHALL clear.
REQ-022 In RUN, the 20-bit bit-time counter SHALL increment each clock.
REQ-023 When the bit-time counter == k_q-1: BTU=1, the counter SHALL wrap to 0, and BIT_CNT SHALL increment.
REQ-024 When BTU fires with BIT_CNT == NBITS-1: DONE=1, BIT_CNT SHALL clear, and the FSM SHALL enter IDLE.
REQ-025 HALF SHALL be 1 when the bit-time counter == k_q>>1, once per bit time.
REQ-026 START SHALL be ignored in LOAD and RUN; there is no queueing.
REQ-027 Latency: the first BTU SHALL occur k_q+1 clocks after the START-sampling edge; subsequent BTUs SHALL occur every k_q clocks.
REQ-028 K changes during RUN SHALL have no effect; only k_q is used.

Reset
REQ-029 On reset: state IDLE; BAUD_SEL=4'b0000; sw_q=4'b0000; k_q=20'd333333; all counters 0.
REQ-030 On reset: BTU, HALF, DONE, CHG, BUSY = 0; BIT_CNT = 0.
REQ-031 Reset asserted mid-frame SHALL abort immediately; DONE SHALL NOT be issued.

Configuration
REQ-032 With BAUD_TICK_HALF_EN defined, HALF SHALL be generated per REQ-025.
REQ-033 Without BAUD_TICK_HALF_EN, HALF SHALL be tied to 0 and its compare logic omitted; all other behaviour SHALL be unchanged.

Verification
REQ-034 BAUD_SEL=4'b1011, K=109, pulse START: first BTU at +110 clocks, then BTUs every 109 clocks, DONE at +1200 with BIT_CNT=10, BUSY high for 1200 clocks.
REQ-035 BAUD_SW 0000->1000 held 20 clocks in IDLE: BAUD_SEL=1000 at clock 17 after the change, one CHG pulse; a frame then uses K=868.
REQ-036 BAUD_SW toggled every 10 clocks (STABLE=16): BAUD_SEL never changes, CHG never pulses.
REQ-037 BAUD_SW changed during RUN: BAUD_SEL unchanged until STABLE clocks after return to IDLE; BTU period unchanged within the frame.
REQ-038 K forced to 1, START: k_q=2, BTU every 2 clocks, 11 BTUs; with BAUD_TICK_HALF_EN and K=109: HALF at counter 54 each bit.
REQ-039 Reset asserted at BIT_CNT=5 mid-frame: all outputs 0 the same cycle, BAUD_SEL=0000, no DONE.
